// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared 640x480 timing constants, totals and comparison helpers
package video_timing_gen_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic int line_total(input int visible, input int front, input int sync_w, input int back);
        return visible + front + sync_w + back;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = line_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // Compared at 11 bits so a limit of exactly 1024 still works.
    function automatic logic below(input coord_t x, input int lim);
        return {1'b0, x} < 11'(lim);
    endfunction

    function automatic logic in_window(input coord_t x, input int lo, input int len);
        return !below(x, lo) && below(x, lo + len);
    endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// rtl/video_timing_gen_sync_delay_line.sv - pix_tick-enabled shift register that idles at the inactive sync level
module sync_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset_n, en};
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH-1:0] stages;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stages <= '1;
            end else if (en) begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel clock divider, raster counters, video enable and delayed sync outputs
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int CLK_DIV    = 4,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic       video_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       pix_tick,
    output logic       frame_tick
);

    localparam int         H_TOTAL  = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int         V_TOTAL  = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int         HS_START = H_VISIBLE + H_FRONT;
    localparam int         VS_START = V_VISIBLE + V_FRONT;
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam coord_t     H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST   = coord_t'(V_TOTAL - 1);

    if (!(CLK_DIV == 1 || CLK_DIV == 2 || CLK_DIV == 4) || SYNC_DELAY < 0 || SYNC_DELAY > 3 ||
        H_TOTAL > 1024 || V_TOTAL > 1024 || H_VISIBLE < 1 || V_VISIBLE < 1 ||
        H_FRONT < 0 || H_SYNC < 0 || H_BACK < 0 || V_FRONT < 0 || V_SYNC < 0 || V_BACK < 0) begin : g_bad_params
        $fatal(1, "video_timing_gen: illegal timing parameters");
    end

    logic [1:0] div;
    logic       started;
    logic       h_wrap;
    logic       v_wrap;
    coord_t     h_next;
    coord_t     v_next;
    logic       hs_int;
    logic       vs_int;

    // The first tick after reset presents (0,0) rather than advancing past it.
    always_comb begin
        h_wrap = (pixel_column == H_LAST);
        v_wrap = (pixel_row == V_LAST);
        h_next = pixel_column;
        v_next = pixel_row;
        if (started) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? '0 : pixel_row + 10'd1;
            end else begin
                h_next = pixel_column + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div          <= '0;
            pix_tick     <= 1'b0;
            started      <= 1'b0;
            pixel_column <= '0;
            pixel_row    <= '0;
            video_on     <= 1'b0;
            frame_tick   <= 1'b0;
            hs_int       <= ~SYNC_ACTIVE;
            vs_int       <= ~SYNC_ACTIVE;
        end else begin
            div        <= (div == DIV_LAST) ? 2'd0 : div + 2'd1;
            pix_tick   <= (div == DIV_LAST);
            frame_tick <= 1'b0;
            if (pix_tick) begin
                started      <= 1'b1;
                pixel_column <= h_next;
                pixel_row    <= v_next;
                video_on     <= below(h_next, H_VISIBLE) && below(v_next, V_VISIBLE);
                frame_tick   <= started && h_wrap && v_wrap;
                hs_int       <= in_window(h_next, HS_START, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vs_int       <= in_window(v_next, VS_START, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

    sync_delay_line #(.DEPTH(SYNC_DELAY)) u_hsync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pix_tick),
        .din     (hs_int),
        .dout    (horiz_sync)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY)) u_vsync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pix_tick),
        .din     (vs_int),
        .dout    (vert_sync)
    );

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen with an arithmetic raster model
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    logic [9:0] col_a, row_a, col_b, row_b, col_c, row_c;
    logic von_a, hs_a, vs_a, pt_a, ft_a;
    logic von_b, hs_b, vs_b, pt_b, ft_b;
    logic von_c, hs_c, vs_c, pt_c, ft_c;

    video_timing_gen dut_a (
        .clk(clk), .reset_n(rst_a), .pixel_column(col_a), .pixel_row(row_a), .video_on(von_a),
        .horiz_sync(hs_a), .vert_sync(vs_a), .pix_tick(pt_a), .frame_tick(ft_a)
    );

    video_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2), .SYNC_DELAY(2)
    ) dut_b (
        .clk(clk), .reset_n(rst_b), .pixel_column(col_b), .pixel_row(row_b), .video_on(von_b),
        .horiz_sync(hs_b), .vert_sync(vs_b), .pix_tick(pt_b), .frame_tick(ft_b)
    );

    video_timing_gen #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .CLK_DIV(1), .SYNC_DELAY(0)
    ) dut_c (
        .clk(clk), .reset_n(rst_c), .pixel_column(col_c), .pixel_row(row_c), .video_on(von_c),
        .horiz_sync(hs_c), .vert_sync(vs_c), .pix_tick(pt_c), .frame_tick(ft_c)
    );

    // Clock edges seen since each reset was released.
    longint ca, cb, cc;
    always @(posedge clk or negedge rst_a) if (!rst_a) ca <= 0; else ca <= ca + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) cb <= 0; else cb <= cb + 1;
    always @(posedge clk or negedge rst_c) if (!rst_c) cc <= 0; else cc <= cc + 1;

    logic [24:0] obs_a, obs_b, obs_c;
    assign obs_a = {col_a, row_a, von_a, hs_a, vs_a, pt_a, ft_a};
    assign obs_b = {col_b, row_b, von_b, hs_b, vs_b, pt_b, ft_b};
    assign obs_c = {col_c, row_c, von_c, hs_c, vs_c, pt_c, ft_c};

    localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    int n_pass = 0;
    int n_total = 0;

    // Expected outputs after c clock edges, from tick counting and raster arithmetic.
    function automatic logic [24:0] model(input int hv, input int hf, input int hsw, input int hb,
                                          input int vv, input int vf, input int vsw, input int vb,
                                          input int dv, input int dly, input longint c);
        longint ht, vt, n, p, q, m;
        logic [9:0] col, row;
        logic von, hs, vs, pt, ft;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        n  = (c >= 1) ? (c - 1) / dv : 0;
        pt = (c >= 1) && (c % dv == 0);
        col = '0; row = '0; von = 1'b0;
        if (n >= 1) begin
            p   = n - 1;
            col = 10'(p % ht);
            row = 10'((p / ht) % vt);
            von = ((p % ht) < hv) && (((p / ht) % vt) < vv);
        end
        ft = (c >= 2) && ((c - 1) % dv == 0) && (n >= 2) && ((n - 1) % (ht * vt) == 0);
        hs = 1'b1; vs = 1'b1;
        m  = n - dly;
        if (m >= 1) begin
            q  = m - 1;
            hs = !(((q % ht) >= hv + hf) && ((q % ht) < hv + hf + hsw));
            vs = !((((q / ht) % vt) >= vv + vf) && (((q / ht) % vt) < vv + vf + vsw));
        end
        return {col, row, von, hs, vs, pt, ft};
    endfunction

    function automatic logic [24:0] exp_sel(input int which, input longint c);
        case (which)
            0:       return model(640, 16, 96, 48, 480, 10, 2, 33, 4, 1, c);
            1:       return model(8, 2, 3, 3, 6, 1, 2, 1, 2, 2, c);
            default: return model(10, 2, 2, 2, 4, 1, 1, 2, 1, 0, c);
        endcase
    endfunction

    function automatic logic [24:0] obs_sel(input int which);
        case (which)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    function automatic longint cnt_sel(input int which);
        case (which)
            0:       return ca;
            1:       return cb;
            default: return cc;
        endcase
    endfunction

    task automatic set_rst(input int which, input logic v);
        case (which)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (obs_a !== RST_VEC) $display("FAIL reset_a: got %h want %h", obs_a, RST_VEC); else n_pass++;
        n_total++; if (obs_b !== RST_VEC) $display("FAIL reset_b: got %h want %h", obs_b, RST_VEC); else n_pass++;
        n_total++; if (obs_c !== RST_VEC) $display("FAIL reset_c: got %h want %h", obs_c, RST_VEC); else n_pass++;
    endtask

    task automatic test_line_timing();
        logic [24:0] e;
        int prev_col = 0, hs_low = 0, fall_col = -1, von_640 = -1, min_gap = 1000, max_gap = 0;
        logic prev_hs = 1'b1;
        longint last_pt = -1;
        longint wraps[$];
        rst_a = 1'b0; @(negedge clk); rst_a = 1'b1;
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            e = exp_sel(0, ca);
            n_total++;
            if (obs_a !== e) $display("FAIL line_stream c=%0d: got %h want %h", ca, obs_a, e); else n_pass++;
            if (pt_a) begin
                if (last_pt >= 0) begin
                    if (int'(ca - last_pt) < min_gap) min_gap = int'(ca - last_pt);
                    if (int'(ca - last_pt) > max_gap) max_gap = int'(ca - last_pt);
                end
                last_pt = ca;
            end
            if (prev_col == 799 && col_a == 10'd0) wraps.push_back(ca);
            if (wraps.size() == 1 && !hs_a) hs_low++;
            if (prev_hs && !hs_a && fall_col < 0) fall_col = int'(col_a);
            if (col_a == 10'd640 && von_640 < 0) von_640 = int'(von_a);
            prev_col = int'(col_a);
            prev_hs  = hs_a;
        end
        n_total++;
        if (min_gap != 4 || max_gap != 4) $display("FAIL pix_tick_period: got %0d..%0d want 4", min_gap, max_gap); else n_pass++;
        n_total++;
        if (wraps.size() < 2 || wraps[1] - wraps[0] != 3200) $display("FAIL line_period: got %0d wraps, span %0d want 3200", wraps.size(), (wraps.size() < 2) ? 0 : wraps[1] - wraps[0]);
        else n_pass++;
        n_total++; if (hs_low != 96 * 4) $display("FAIL hsync_width: got %0d clk want %0d", hs_low, 96 * 4); else n_pass++;
        n_total++; if (fall_col != 657) $display("FAIL hsync_first_col: got %0d want 657", fall_col); else n_pass++;
        n_total++; if (von_640 != 0) $display("FAIL video_on_col640: got %0d want 0", von_640); else n_pass++;
    endtask

    task automatic test_frame();
        logic [24:0] e;
        int von_cnt = 0, vs_low = 0, hs_low = 0;
        longint fts[$];
        rst_b = 1'b0; @(negedge clk); rst_b = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            e = exp_sel(1, cb);
            n_total++;
            if (obs_b !== e) $display("FAIL frame_stream c=%0d: got %h want %h", cb, obs_b, e); else n_pass++;
            if (ft_b) fts.push_back(cb);
            if (fts.size() == 1) begin
                if (von_b) von_cnt++;
                if (!vs_b) vs_low++;
                if (!hs_b) hs_low++;
            end
        end
        n_total++; if (fts.size() != 3) $display("FAIL frame_tick_count: got %0d want 3", fts.size()); else n_pass++;
        n_total++;
        if (fts.size() < 2 || fts[1] - fts[0] != 320) $display("FAIL frame_period: got %0d want 320", (fts.size() < 2) ? 0 : fts[1] - fts[0]);
        else n_pass++;
        n_total++; if (von_cnt != 8 * 6 * 2) $display("FAIL video_on_per_frame: got %0d want %0d", von_cnt, 8 * 6 * 2); else n_pass++;
        n_total++; if (vs_low != 2 * 16 * 2) $display("FAIL vsync_per_frame: got %0d want %0d", vs_low, 2 * 16 * 2); else n_pass++;
        n_total++; if (hs_low != 3 * 10 * 2) $display("FAIL hsync_per_frame: got %0d want %0d", hs_low, 3 * 10 * 2); else n_pass++;
    endtask

    task automatic test_continuous();
        logic [24:0] e;
        int pt_low = 0, falls = 0, bad_falls = 0, ft_cnt = 0;
        logic prev_hs = 1'b1;
        rst_c = 1'b0; @(negedge clk); rst_c = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            e = exp_sel(2, cc);
            n_total++;
            if (obs_c !== e) $display("FAIL cont_stream c=%0d: got %h want %h", cc, obs_c, e); else n_pass++;
            if (!pt_c) pt_low++;
            if (ft_c) ft_cnt++;
            if (prev_hs && !hs_c) begin
                falls++;
                if (col_c != 10'd12) bad_falls++;
            end
            prev_hs = hs_c;
        end
        n_total++; if (pt_low != 0) $display("FAIL pix_tick_continuous: got %0d low samples want 0", pt_low); else n_pass++;
        n_total++; if (falls != 25 || bad_falls != 0) $display("FAIL hsync_fall_col: got %0d falls, %0d off column 12, want 25 and 0", falls, bad_falls); else n_pass++;
        n_total++; if (ft_cnt != 3) $display("FAIL cont_frame_ticks: got %0d want 3", ft_cnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        int which, run;
        logic [24:0] e;
        for (int k = 0; k < 5; k++) begin
            which = (k == 0) ? 0 : int'($urandom_range(0, 2));
            case (which)
                0:       run = 4 * (int'($urandom_range(690, 720)) + 1) + int'($urandom_range(0, 3));
                1:       run = int'($urandom_range(50, 700));
                default: run = int'($urandom_range(20, 300));
            endcase
            set_rst(which, 1'b0); @(negedge clk); set_rst(which, 1'b1);
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                e = exp_sel(which, cnt_sel(which));
                n_total++;
                if (obs_sel(which) !== e) $display("FAIL pre_reset_stream dut%0d c=%0d: got %h want %h", which, cnt_sel(which), obs_sel(which), e); else n_pass++;
            end
            #($urandom_range(1, 3));
            set_rst(which, 1'b0);
            #1;
            n_total++;
            if (obs_sel(which) !== RST_VEC) $display("FAIL async_reset dut%0d: got %h want %h", which, obs_sel(which), RST_VEC); else n_pass++;
            @(negedge clk);
            set_rst(which, 1'b1);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                e = exp_sel(which, cnt_sel(which));
                n_total++;
                if (obs_sel(which) !== e) $display("FAIL restart_stream dut%0d c=%0d: got %h want %h", which, cnt_sel(which), obs_sel(which), e); else n_pass++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_continuous();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter CLK_DIV, default 4, clk cycles per pixel; legal values are 1, 2 and 4.
REQ-006 Parameter SYNC_DELAY, default 1, pixel ticks that sync outputs lag coordinates, to match the registered pixel colour path; legal range is 0..3.
REQ-007 Port clk, input, 1 bit: system clock, rising edge.
REQ-008 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port pixel_column, output, 10 bits: current horizontal count.
REQ-010 Port pixel_row, output, 10 bits: current vertical count.
REQ-011 Port video_on, output, 1 bit: high when the current pixel is inside the visible region; drives the colour stage's video enable.
REQ-012 Port horiz_sync, output, 1 bit: active-low horizontal sync.
REQ-013 Port vert_sync, output, 1 bit: active-low vertical sync.
REQ-014 Port pix_tick, output, 1 bit: one-clk pulse marking each pixel advance.
REQ-015 Port frame_tick, output, 1 bit: one-clk pulse at the start of each frame (column 0, row 0).

Function
REQ-016 Divider: modulo-CLK_DIV counter; pix_tick is asserted for one clk when the counter equals CLK_DIV-1. With CLK_DIV=1, pix_tick is high every cycle.
REQ-017 Horizontal counter h: increments on pix_tick and wraps from H_TOTAL-1 to 0, where H_TOTAL = sum of the four H parameters (default 800).
REQ-018 Vertical counter v: increments on a pix_tick where h wraps, and wraps from V_TOTAL-1 to 0 (default V_TOTAL 525).
REQ-019 Simultaneous wrap (h = H_TOTAL-1 and v = V_TOTAL-1 on a pix_tick): both counters go to 0 on the same edge.
REQ-020 pixel_column = h and pixel_row = v, both registered; outputs change only on the edge after pix_tick.
REQ-021 video_on is registered and is high exactly when h < H_VISIBLE and v < V_VISIBLE; it updates on the same edge as the coordinates.
REQ-022 Internal horizontal sync is low for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
REQ-023 Internal vertical sync is low for V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (default 490..491).
REQ-024 horiz_sync and vert_sync are the internal syncs delayed through a SYNC_DELAY-stage shift register that advances only on pix_tick; SYNC_DELAY=0 gives direct registered syncs aligned with the coordinates.
REQ-025 frame_tick is high for one clk on the edge where h and v both become 0.
REQ-026 Widths: counters are 10 bits; H_TOTAL and V_TOTAL are <= 1024. Violating parameter values are a fatal elaboration error (simulation assertion).
REQ-027 Counters never exceed TOTAL-1, including the first frame after reset.

Reset
REQ-028 On reset_n low, immediately and asynchronously: divider = 0, h = 0, v = 0, pixel_column = 0, pixel_row = 0, video_on = 0, pix_tick = 0, frame_tick = 0.
REQ-029 On reset_n low: horiz_sync = 1, vert_sync = 1, and all sync delay stages = 1.
REQ-030 Reset asserted mid-line or mid-frame discards position; no partial sync pulse continues.
REQ-031 After reset_n deasserts, the first pix_tick occurs CLK_DIV clks later and the first pixel is (0,0). frame_tick is not asserted for this initial (0,0).

Structure
REQ-032 Shared package: default 640x480 timing constants, H_TOTAL/V_TOTAL derivation, and sync polarity constant (active-low).
REQ-033 One sub-module, sync_delay_line: parameterised depth, pix_tick-enabled shift register with reset value 1, instantiated once per sync signal.

Verification
REQ-034 Defaults, reset released: pix_tick every 4th clk; pixel_column counts 0..799 and wraps; one line = 3200 clk.
REQ-035 Defaults: horiz_sync is low for exactly 96 pixel ticks per line, first low while pixel_column = 657 (SYNC_DELAY=1); vert_sync is low for 2 lines per frame.
REQ-036 Defaults: video_on is high for 640x480 = 307200 pixel ticks per frame, and low at column 640 and at row 480.
REQ-037 Frame wrap: at column 799, row 524, the next pix_tick gives (0,0) with frame_tick high for exactly one clk; the frame period is 420000 pixel ticks.
REQ-038 reset_n pulsed low at column 700, row 100: outputs return to their reset values within the same cycle; after release, the count restarts at (0,0) and both syncs are high.
REQ-039 CLK_DIV=1, SYNC_DELAY=0: pix_tick is continuous; horiz_sync falls on the same edge that pixel_column becomes 656.
